// File: rtl/neuron_state_bank_pkg.sv
// Shared constants and FSM encoding for the per-neuron v/u state bank.
// The state-word width is also used by the Izhikevich datapath.
package neuron_state_bank_pkg;

    localparam int unsigned NUMWIDTH_DEF   = 16;
    localparam int unsigned NUMNEURONS_DEF = 16;
    localparam int unsigned TAGBITS_DEF    = 4;

    // One state word: 1 sign + 8 integer + 8 fraction bits.
    localparam int unsigned STATE_W = NUMWIDTH_DEF + 1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } bank_state_e;

endpackage

// File: rtl/neuron_state_bank_ram_1r1w.sv
// Plain synchronous 1-write/1-read array with a registered read port.
// The read returns the pre-write contents on a same-address collision.
module state_ram_1r1w #(
    parameter int unsigned Width = 34,
    parameter int unsigned Depth = 16,
    parameter int unsigned AddrW = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    // Contents are never cleared; the init sweep overwrites them.
    always_ff @(posedge clk_i) begin
        if (we_i && !rst_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/neuron_state_bank.sv
// Per-neuron v/u state store: init sweep sequencer, user write/read ports,
// read-during-write forwarding and rejected-access reporting.
module neuron_state_bank
    import neuron_state_bank_pkg::*;
#(
    parameter int unsigned numwidth   = NUMWIDTH_DEF,
    parameter int unsigned numneurons = NUMNEURONS_DEF,
    parameter int unsigned tagbits    = TAGBITS_DEF
) (
    input  logic                clk,
    input  logic                syn_reset,
    input  logic                init_req,
    input  logic [numwidth:0]   v_init,
    input  logic [numwidth:0]   u_init,
    input  logic                wr_en,
    input  logic [tagbits-1:0]  wr_tag,
    input  logic [numwidth:0]   v_new,
    input  logic [numwidth:0]   u_new,
    input  logic                rd_en,
    input  logic [tagbits-1:0]  rd_tag,
    output logic [numwidth:0]   v,
    output logic [numwidth:0]   u,
    output logic                rd_valid,
    output logic                init_busy,
    output logic                drop
);

    localparam int unsigned W     = numwidth + 1;
    localparam int unsigned WordW = 2 * W;

    bank_state_e        state_q, state_d;
    logic [tagbits-1:0] ptr_q, ptr_d;
    logic               rd_valid_q, rd_valid_d;
    logic               drop_q, drop_d;
    logic               fwd_q;
    logic [WordW-1:0]   fwd_word_q;

    logic               ram_we, ram_re, fwd_hit;
    logic [tagbits-1:0] ram_waddr;
    logic [WordW-1:0]   ram_wdata, ram_rdata, word_out;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rd_valid_d = 1'b0;
        drop_d     = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_waddr  = wr_tag;
        ram_wdata  = {v_new, u_new};
        fwd_hit    = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                ram_we    = 1'b1;
                ram_waddr = ptr_q;
                ram_wdata = {v_init, u_init};
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == tagbits'(numneurons - 1)) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end
                drop_d = rd_en | wr_en;
            end
            ST_IDLE: begin
                ram_we     = wr_en;
                ram_re     = rd_en;
                rd_valid_d = rd_en;
                fwd_hit    = wr_en && rd_en && (wr_tag == rd_tag);
                if (init_req) begin
                    state_d = ST_INIT;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (syn_reset) begin
            state_q    <= ST_INIT;
            ptr_q      <= '0;
            rd_valid_q <= 1'b0;
            drop_q     <= 1'b0;
            fwd_q      <= 1'b0;
            fwd_word_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rd_valid_q <= rd_valid_d;
            drop_q     <= drop_d;
            // Forward selection only changes on a read so idle cycles hold v/u.
            if (ram_re) begin
                fwd_q      <= fwd_hit;
                fwd_word_q <= {v_new, u_new};
            end
        end
    end

    state_ram_1r1w #(
        .Width (WordW),
        .Depth (numneurons),
        .AddrW (tagbits)
    ) u_ram (
        .clk_i   (clk),
        .rst_i   (syn_reset),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (rd_tag),
        .rdata_o (ram_rdata)
    );

    assign word_out  = fwd_q ? fwd_word_q : ram_rdata;
    assign v         = word_out[WordW-1:W];
    assign u         = word_out[W-1:0];
    assign rd_valid  = rd_valid_q;
    assign drop      = drop_q;
    assign init_busy = (state_q == ST_INIT);

endmodule
